decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter INST_MEM_WIDTH, default 2, PC width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, stall counter width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  upstream handshake for inst, pc, pc1.
REQ-006 inst  in  32  instruction word.
REQ-007 pc, pc1  in  INST_MEM_WIDTH each  fetch PCs.
REQ-008 flush  in  1  squash held and incoming instruction.
REQ-009 wb_en, wb_addr, wb_data  in  1 / 5 / 32  register-file write port.
REQ-010 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-011 op1, op2  out  32 each  registered source operands.
REQ-012 rt, rd, sa, immediate, inst_index  out  5 / 5 / 5 / 16 / 26  registered fields.
REQ-013 pc_next, pc1_next  out  INST_MEM_WIDTH each  registered PCs.
REQ-014 RegWrite, MemtoReg[1:0], ALUSrcs[1:0], ALUSrcs2, ALUOp[3:0], RegDist[1:0], Branch[1:0], MemWrite, MemRead, UARTtoReg, RegtoUART  out  registered control from operator decoder.
REQ-015 stall_count  out  CNT_WIDTH  load-use bubble count.

Function
REQ-016 Field split: opcode inst[31:26], rs [25:21], rt [20:16], rd [15:11], sa [10:6], funct [5:0], immediate [15:0], inst_index [25:0].
REQ-017 Internal 32x32 register file; reads combinational on rs, rt; reg 0 reads 0, writes to 0 ignored.
REQ-018 Output register loads on accept (in_valid && in_ready); latency exactly 1 cycle inst -> outputs.
REQ-019 Hazard = out_valid && MemRead (held) && held rt != 0 && (held rt == inst rs || held rt == inst rt), evaluated only when in_valid.
REQ-020 in_ready = flush || ((!out_valid || out_ready) && !hazard).
REQ-021 Hazard with out_ready=1: held load leaves, out_valid<=0 (bubble), stall_count += 1; next cycle instruction is accepted.
REQ-022 Hazard with out_ready=0: all state held, no count.
REQ-023 out_valid=1 and out_ready=0: all outputs stable.
REQ-024 Output drained, nothing accepted: out_valid<=0; data fields hold values.
REQ-025 flush highest priority: out_valid<=0 next cycle; incoming instruction consumed and discarded; no count.
REQ-026 Register-file write on wb_en independent of stall/flush.
REQ-027 stall_count saturates at all-ones.

Reset
REQ-028 reset SHALL force out_valid=0, all registered outputs and control to 0, stall_count=0, in_ready=0 during reset.
REQ-029 Register-file contents SHALL be cleared to 0 by reset.
REQ-030 reset mid-hazard or mid-stall SHALL discard pending instruction; first accept permitted cycle after reset deasserts.

Configuration
REQ-031 Macro DECODE_WB_BYPASS_EN defined: read of rs/rt equal to wb_addr (nonzero) with wb_en returns wb_data in same cycle.
REQ-032 Macro undefined: same-cycle read returns old value; new value visible from next cycle.

Verification
REQ-033 Reset, write wb r5=0x1234, then inst rs=5 rt=0 -> one cycle later out_valid=1, op1=0x00001234, op2=0.
REQ-034 lw writes r8, next inst add rs=8, out_ready=1 -> one bubble (out_valid=0 one cycle), stall_count=1, add issued next cycle.
REQ-035 Same-cycle wb_en r3=0xAAAA55 with inst rs=3 -> op1=0xAAAA55 with DECODE_WB_BYPASS_EN, prior r3 value without.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; release -> next instruction accepted.
REQ-037 flush asserted with held valid and in_valid=1 -> out_valid=0 next cycle, in_ready=1, stall_count unchanged.
REQ-038 Write r0=0xFFFFFFFF, read rs=0 -> op1=0.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage with register file and load-use stall.
// Optional DECODE_WB_BYPASS_EN forwards a same-cycle writeback to operand reads.
module decode_pipe #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               inst,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic                      flush,
  input  logic                      wb_en,
  input  logic [4:0]                wb_addr,
  input  logic [31:0]               wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               op1,
  output logic [31:0]               op2,
  output logic [4:0]                rt,
  output logic [4:0]                rd,
  output logic [4:0]                sa,
  output logic [15:0]               immediate,
  output logic [25:0]               inst_index,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic                      RegWrite,
  output logic [1:0]                MemtoReg,
  output logic [1:0]                ALUSrcs,
  output logic                      ALUSrcs2,
  output logic [3:0]                ALUOp,
  output logic [1:0]                RegDist,
  output logic [1:0]                Branch,
  output logic                      MemWrite,
  output logic                      MemRead,
  output logic                      UARTtoReg,
  output logic                      RegtoUART,
  output logic [CNT_WIDTH-1:0]      stall_count
);

  // {RegWrite, MemtoReg, ALUSrcs, ALUSrcs2, ALUOp, RegDist,
  //  Branch, MemWrite, MemRead, UARTtoReg, RegtoUART}
  localparam logic [17:0] C_RTYPE = 18'b1_00_00_0_0010_01_00_0_0_0_0;
  localparam logic [17:0] C_SHIFT = 18'b1_00_01_0_0010_01_00_0_0_0_0;
  localparam logic [17:0] C_ADDI  = 18'b1_00_00_1_0000_00_00_0_0_0_0;
  localparam logic [17:0] C_ANDI  = 18'b1_00_00_1_0011_00_00_0_0_0_0;
  localparam logic [17:0] C_ORI   = 18'b1_00_00_1_0100_00_00_0_0_0_0;
  localparam logic [17:0] C_LW    = 18'b1_01_00_1_0000_00_00_0_1_0_0;
  localparam logic [17:0] C_SW    = 18'b0_00_00_1_0000_00_00_1_0_0_0;
  localparam logic [17:0] C_BEQ   = 18'b0_00_00_0_0001_00_01_0_0_0_0;
  localparam logic [17:0] C_BNE   = 18'b0_00_00_0_0001_00_10_0_0_0_0;
  localparam logic [17:0] C_J     = 18'b0_00_00_0_0000_00_11_0_0_0_0;
  localparam logic [17:0] C_JAL   = 18'b1_10_10_0_0000_10_11_0_0_0_0;
  localparam logic [17:0] C_UIN   = 18'b1_11_00_0_0000_00_00_0_0_1_0;
  localparam logic [17:0] C_UOUT  = 18'b0_00_00_0_0000_00_00_0_0_0_1;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [31:0] rf [32];
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [17:0] dec;
  logic [17:0] ctrl_q;
  logic        hazard;
  logic        accept;

  assign opcode = inst[31:26];
  assign rs_a   = inst[25:21];
  assign rt_a   = inst[20:16];
  assign funct  = inst[5:0];

  always_comb begin
    rs_val = (rs_a == 5'd0) ? 32'd0 : rf[rs_a];
    rt_val = (rt_a == 5'd0) ? 32'd0 : rf[rt_a];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr != 5'd0 && wb_addr == rs_a)
      rs_val = wb_data;
    if (wb_en && wb_addr != 5'd0 && wb_addr == rt_a)
      rt_val = wb_data;
`endif
  end

  always_comb begin
    dec = '0;
    unique case (opcode)
      6'h00: begin
        if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)
          dec = C_SHIFT;
        else
          dec = C_RTYPE;
      end
      6'h08:   dec = C_ADDI;
      6'h0c:   dec = C_ANDI;
      6'h0d:   dec = C_ORI;
      6'h23:   dec = C_LW;
      6'h2b:   dec = C_SW;
      6'h04:   dec = C_BEQ;
      6'h05:   dec = C_BNE;
      6'h02:   dec = C_J;
      6'h03:   dec = C_JAL;
      6'h3e:   dec = C_UIN;
      6'h3f:   dec = C_UOUT;
      default: dec = '0;
    endcase
  end

  assign {RegWrite, MemtoReg, ALUSrcs, ALUSrcs2, ALUOp, RegDist,
          Branch, MemWrite, MemRead, UARTtoReg, RegtoUART} = ctrl_q;

  // Held load whose destination feeds the incoming instruction.
  assign hazard = in_valid && out_valid && MemRead && rt != 5'd0 &&
                  (rt == rs_a || rt == rt_a);

  assign in_ready = !reset &&
                    (flush || ((!out_valid || out_ready) && !hazard));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
      out_valid   <= 1'b0;
      op1         <= '0;
      op2         <= '0;
      rt          <= '0;
      rd          <= '0;
      sa          <= '0;
      immediate   <= '0;
      inst_index  <= '0;
      pc_next     <= '0;
      pc1_next    <= '0;
      ctrl_q      <= '0;
      stall_count <= '0;
    end else begin
      if (wb_en && wb_addr != 5'd0)
        rf[wb_addr] <= wb_data;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        op1        <= rs_val;
        op2        <= rt_val;
        rt         <= rt_a;
        rd         <= inst[15:11];
        sa         <= inst[10:6];
        immediate  <= inst[15:0];
        inst_index <= inst[25:0];
        pc_next    <= pc;
        pc1_next   <= pc1;
        ctrl_q     <= dec;
      end else if (hazard && out_ready) begin
        out_valid <= 1'b0;
        if (stall_count != '1)
          stall_count <= stall_count + CNT_WIDTH'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: vector table plus scoreboard for decode_pipe.
// Small CNT_WIDTH so the stall counter saturates quickly.
module tb_decode_pipe;

  localparam int PW = 2;
  localparam int CW = 3;

  localparam logic [17:0] C_R    = 18'b1_00_00_0_0010_01_00_0_0_0_0;
  localparam logic [17:0] C_SLL  = 18'b1_00_01_0_0010_01_00_0_0_0_0;
  localparam logic [17:0] C_ADDI = 18'b1_00_00_1_0000_00_00_0_0_0_0;
  localparam logic [17:0] C_ANDI = 18'b1_00_00_1_0011_00_00_0_0_0_0;
  localparam logic [17:0] C_ORI  = 18'b1_00_00_1_0100_00_00_0_0_0_0;
  localparam logic [17:0] C_LW   = 18'b1_01_00_1_0000_00_00_0_1_0_0;
  localparam logic [17:0] C_SW   = 18'b0_00_00_1_0000_00_00_1_0_0_0;
  localparam logic [17:0] C_BEQ  = 18'b0_00_00_0_0001_00_01_0_0_0_0;
  localparam logic [17:0] C_BNE  = 18'b0_00_00_0_0001_00_10_0_0_0_0;
  localparam logic [17:0] C_J    = 18'b0_00_00_0_0000_00_11_0_0_0_0;
  localparam logic [17:0] C_JAL  = 18'b1_10_10_0_0000_10_11_0_0_0_0;
  localparam logic [17:0] C_UIN  = 18'b1_11_00_0_0000_00_00_0_0_1_0;
  localparam logic [17:0] C_UOUT = 18'b0_00_00_0_0000_00_00_0_0_0_1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   inst;
  logic [PW-1:0] pc;
  logic [PW-1:0] pc1;
  logic          flush;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   op1;
  logic [31:0]   op2;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    sa;
  logic [15:0]   immediate;
  logic [25:0]   inst_index;
  logic [PW-1:0] pc_next;
  logic [PW-1:0] pc1_next;
  logic          RegWrite;
  logic [1:0]    MemtoReg;
  logic [1:0]    ALUSrcs;
  logic          ALUSrcs2;
  logic [3:0]    ALUOp;
  logic [1:0]    RegDist;
  logic [1:0]    Branch;
  logic          MemWrite;
  logic          MemRead;
  logic          UARTtoReg;
  logic          RegtoUART;
  logic [CW-1:0] stall_count;

  decode_pipe #(.INST_MEM_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .pc1(pc1), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .rt(rt), .rd(rd), .sa(sa),
    .immediate(immediate), .inst_index(inst_index),
    .pc_next(pc_next), .pc1_next(pc1_next),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcs(ALUSrcs), .ALUSrcs2(ALUSrcs2), .ALUOp(ALUOp),
    .RegDist(RegDist), .Branch(Branch),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .UARTtoReg(UARTtoReg), .RegtoUART(RegtoUART),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [17:0] ctrl;
  } vec_t;

  typedef struct {
    logic [31:0]   op1;
    logic [31:0]   op2;
    logic [56:0]   fields;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc1;
    logic [17:0]   ctrl;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb [$];
  logic [31:0] mdl [32];
  logic [17:0] cur_ctrl;
  logic        acc;
  logic        rdy_s;
  int          pcn = 0;
  int          n;
  logic [CW-1:0] sc0;
  vec_t        vt [13];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op,
    input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
    input logic [4:0] sh, input logic [5:0] fn);
    return {op, s, t, d, sh, fn};
  endfunction

  function automatic logic [31:0] mki(input logic [5:0] op,
    input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return mdl[a];
  endfunction

  task automatic cycle();
    exp_t e;
    exp_t g;
    @(negedge clk);
    rdy_s = in_ready;
    acc   = in_valid && in_ready;
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          g.op1 = op1;
          g.op2 = op2;
          chk("sb_op1", op1, e.op1);
          chk("sb_op2", op2, e.op2);
          chk("sb_fields", {rt, rd, sa, immediate, inst_index},
              e.fields);
          chk("sb_pcs", {pc_next, pc1_next}, {e.pc, e.pc1});
          chk("sb_ctrl", {RegWrite, MemtoReg, ALUSrcs, ALUSrcs2,
              ALUOp, RegDist, Branch, MemWrite, MemRead,
              UARTtoReg, RegtoUART}, e.ctrl);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (acc) begin
        e.op1    = rf_read(inst[25:21]);
        e.op2    = rf_read(inst[20:16]);
        e.fields = {inst[20:16], inst[15:11], inst[10:6],
                    inst[15:0], inst[25:0]};
        e.pc     = pc;
        e.pc1    = pc1;
        e.ctrl   = cur_ctrl;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      mdl[wb_addr] = wb_data;
    end
    #1;
    if (acc && !flush && !reset) chk("latency_valid", out_valid, 1);
  endtask

  task automatic issue(input logic [31:0] i, input logic [17:0] c,
                       output int cnt);
    in_valid = 1'b1;
    inst     = i;
    cur_ctrl = c;
    pc       = PW'(pcn);
    pc1      = PW'(pcn + 1);
    cnt      = 0;
    do begin
      cycle();
      cnt++;
    end while (!acc && cnt < 20);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    pcn++;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    cycle();
    wb_en   = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    vt[0]  = '{mk(6'h00, 1, 2, 10, 0, 6'h20),       C_R};
    vt[1]  = '{mk(6'h00, 0, 4, 11, 5, 6'h00),       C_SLL};
    vt[2]  = '{mki(6'h08, 2, 12, 16'h8001),          C_ADDI};
    vt[3]  = '{mki(6'h0c, 4, 13, 16'h00ff),          C_ANDI};
    vt[4]  = '{mki(6'h0d, 1, 14, 16'hf0f0),          C_ORI};
    vt[5]  = '{mki(6'h23, 2, 9, 16'h0004),           C_LW};
    vt[6]  = '{mki(6'h2b, 1, 4, 16'h0008),           C_SW};
    vt[7]  = '{mki(6'h04, 1, 2, 16'h0010),           C_BEQ};
    vt[8]  = '{mki(6'h05, 4, 0, 16'hfffe),           C_BNE};
    vt[9]  = '{{6'h02, 26'h3ffffff},                 C_J};
    vt[10] = '{{6'h03, 26'h0123456},                 C_JAL};
    vt[11] = '{mki(6'h3e, 0, 15, 16'h0000),          C_UIN};
    vt[12] = '{mki(6'h3f, 15, 0, 16'h0000),          C_UOUT};

    for (int i = 0; i < 32; i++) mdl[i] = '0;
    reset = 1'b1; in_valid = 0; inst = '0; pc = '0; pc1 = '0;
    flush = 0; wb_en = 0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b1; cur_ctrl = '0;

    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_op1", op1, 0);
    chk("rst_ctrl", {RegWrite, MemtoReg, ALUOp, MemRead, Branch}, 0);
    reset = 1'b0;

    wb(5, 32'h1234);
    issue(mk(6'h00, 5, 0, 1, 0, 6'h20), C_R, n);
    chk("r5_out_valid", out_valid, 1);
    chk("r5_op1", op1, 32'h00001234);
    chk("r5_op2", op2, 0);
    idle(2);

    wb(1, 32'h11111111);
    wb(2, 32'h00000022);
    wb(4, 32'hdeadbeef);
    for (int i = 0; i < 13; i++) begin
      issue(vt[i].inst, vt[i].ctrl, n);
      chk("vec_no_stall", n, 1);
    end
    idle(2);

    wb(0, 32'hffffffff);
    issue(mk(6'h00, 0, 0, 2, 0, 6'h20), C_R, n);
    chk("r0_op1", op1, 0);
    idle(2);

    wb(3, 32'h77);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h00aaaa55;
    issue(mk(6'h00, 3, 0, 7, 0, 6'h20), C_R, n);
    wb_en = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_op1", op1, 32'h00aaaa55);
`else
    chk("bypass_op1", op1, 32'h77);
`endif
    idle(1);
    issue(mk(6'h00, 3, 0, 7, 0, 6'h20), C_R, n);
    chk("r3_next_op1", op1, 32'h00aaaa55);
    idle(2);

    issue(mki(6'h23, 0, 8, 16'h0010), C_LW, n);
    in_valid = 1'b1; inst = mk(6'h00, 8, 0, 9, 0, 6'h20);
    cur_ctrl = C_R; pc = PW'(pcn); pc1 = PW'(pcn + 1);
    cycle();
    chk("hazard_in_ready", rdy_s, 0);
    chk("bubble_valid", out_valid, 0);
    chk("bubble_stall", stall_count, 1);
    cycle();
    chk("after_bubble_acc", acc, 1);
    in_valid = 1'b0; pcn++;
    idle(2);

    wb(6, 32'h66);
    out_ready = 1'b0;
    issue(mk(6'h00, 6, 0, 1, 0, 6'h20), C_R, n);
    in_valid = 1'b1; inst = mk(6'h00, 1, 2, 3, 0, 6'h20);
    cur_ctrl = C_R; pc = PW'(pcn); pc1 = PW'(pcn + 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_in_ready", rdy_s, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_op1", op1, 32'h66);
      chk("hold_rd", rd, 1);
    end
    out_ready = 1'b1;
    cycle();
    chk("release_acc", acc, 1);
    in_valid = 1'b0; pcn++;
    idle(2);

    sc0 = stall_count;
    out_ready = 1'b0;
    issue(mk(6'h00, 6, 0, 1, 0, 6'h20), C_R, n);
    in_valid = 1'b1; flush = 1'b1;
    inst = mk(6'h00, 2, 2, 4, 0, 6'h20);
    cycle();
    chk("flush_in_ready", rdy_s, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_stall", stall_count, sc0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(2);

    for (int k = 0; k < 8; k++) begin
      issue(mki(6'h23, 0, 8, 16'h0000), C_LW, n);
      issue(mk(6'h00, 0, 8, 9, 0, 6'h20), C_R, n);
      chk("ldu_wait", n, 2);
    end
    chk("stall_saturated", stall_count, 3'b111);
    idle(2);

    out_ready = 1'b0;
    issue(mki(6'h23, 0, 8, 16'h0000), C_LW, n);
    in_valid = 1'b1; inst = mk(6'h00, 8, 0, 9, 0, 6'h20);
    cur_ctrl = C_R;
    cycle();
    cycle();
    chk("hz_hold_in_ready", rdy_s, 0);
    chk("hz_hold_valid", out_valid, 1);
    chk("hz_hold_stall", stall_count, 3'b111);
    reset = 1'b1;
    cycle();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_stall", stall_count, 0);
    reset = 1'b0; out_ready = 1'b1;
    cycle();
    chk("post_rst_acc", acc, 1);
    in_valid = 1'b0;
    cycle();
    chk("post_rst_op1", op1, 0);
    idle(2);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
